// File: rtl/bus_rr_arbiter_pkg.sv
// rtl/bus_rr_arbiter_pkg.sv - shared bus types, CTI codes and helpers for the round-robin arbiter
package bus_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Index of the set bit in a one-hot vector of up to four masters.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// rtl/bus_rr_arbiter_rr_pick.sv - combinational round-robin pick starting after the last owner
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  next,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        next  = '0;
        valid = 1'b0;
        cand  = '0;
        // last itself is searched last, so a lone re-request by the previous owner still wins
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!valid && req[cand]) begin
                next[cand] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - Wishbone round-robin arbiter: N masters onto one slave, with stall watchdog
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 30,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_cyc,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_w,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_sel,
    input  logic [NUM_MASTERS*3-1:0]      m_cti,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [DATA_W-1:0]             m_dat_r,
    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_adr,
    output logic [DATA_W-1:0]             s_dat_w,
    output logic [DATA_W/8-1:0]           s_sel,
    output logic [2:0]                    s_cti,
    input  logic                          s_ack,
    input  logic                          s_err,
    input  logic [DATA_W-1:0]             s_dat_r,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          timeout_event
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DATA_W / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t       state;
    logic [IW-1:0]    last_owner;
    logic [CW-1:0]    wd_cnt;
    logic             abort_err;

    logic [NUM_MASTERS-1:0] pick_next;
    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;
    logic                   owner_cyc;
    logic                   stall;

    rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req   (m_cyc),
        .last  (last_owner),
        .next  (pick_next),
        .valid (pick_valid)
    );

    assign pick_idx  = IW'(onehot_to_idx(4'(pick_next)));
    assign owner_cyc = m_cyc[last_owner];

    // last_owner is the current owner while OWNED/ABORT, so one mux index serves every state
    assign s_cyc   = (state == ST_OWNED) && owner_cyc;
    assign s_stb   = (state == ST_OWNED) && m_stb[last_owner];
    assign s_we    = m_we[last_owner];
    assign s_adr   = m_adr[int'(last_owner)*ADDR_W +: ADDR_W];
    assign s_dat_w = m_dat_w[int'(last_owner)*DATA_W +: DATA_W];
    assign s_sel   = m_sel[int'(last_owner)*SW +: SW];
    assign s_cti   = m_cti[int'(last_owner)*3 +: 3];
    assign m_dat_r = s_dat_r;

    assign stall = s_stb && !s_ack && !s_err;

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (state == ST_OWNED) begin
            m_ack[last_owner] = s_ack;
            m_err[last_owner] = s_err;
        end
        if (abort_err) m_err[last_owner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            grant         <= '0;
            last_owner    <= IW'(NUM_MASTERS - 1);
            wd_cnt        <= '0;
            timeout_event <= 1'b0;
            abort_err     <= 1'b0;
        end else begin
            timeout_event <= 1'b0;
            abort_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (pick_valid) begin
                        state      <= ST_OWNED;
                        grant      <= pick_next;
                        last_owner <= pick_idx;
                    end
                end
                ST_OWNED: begin
                    if (!owner_cyc) begin
                        wd_cnt <= '0;
                        if (pick_valid) begin
                            grant      <= pick_next;
                            last_owner <= pick_idx;
                        end else begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end
                    end else if (stall) begin
                        if (TIMEOUT_CYCLES != 0 && wd_cnt == WD_LAST) begin
                            state         <= ST_ABORT;
                            timeout_event <= 1'b1;
                            abort_err     <= 1'b1;
                            wd_cnt        <= '0;
                        end else if (TIMEOUT_CYCLES != 0) begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end else if (s_ack || s_err) begin
                        wd_cnt <= '0;
                    end
                end
                ST_ABORT: begin
                    wd_cnt <= '0;
                    if (!owner_cyc) begin
                        if (pick_valid) begin
                            state      <= ST_OWNED;
                            grant      <= pick_next;
                            last_owner <= pick_idx;
                        end else begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - directed and randomized bench for bus_rr_arbiter against a behavioural model
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [N*SW-1:0] m_sel;
    logic [N*3-1:0]  m_cti;
    logic [N-1:0]    m_ack, m_err;
    logic [DW-1:0]   m_dat_r;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_w;
    logic [SW-1:0]   s_sel;
    logic [2:0]      s_cti;
    logic            s_ack, s_err;
    logic [DW-1:0]   s_dat_r;
    logic [N-1:0]    grant;
    logic            timeout_event;

    int n_cmp = 0;
    int n_bad = 0;

    int ref_owner;
    int ref_last;
    int ref_stall;
    bit ref_abort;
    bit ref_pulse;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti),
        .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti),
        .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
        .grant(grant), .timeout_event(timeout_event)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_winner();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (ref_last + k) % N;
            if (m_cyc[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ref_owner = -1;
        ref_last  = N - 1;
        ref_stall = 0;
        ref_abort = 1'b0;
        ref_pulse = 1'b0;
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg, ea, ee;
        bit live;
        live = (ref_owner >= 0) && !ref_abort;
        eg = '0; ea = '0; ee = '0;
        if (ref_owner >= 0) begin
            eg[ref_owner] = 1'b1;
            ea[ref_owner] = live && s_ack;
            ee[ref_owner] = (live && s_err) || ref_pulse;
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("m_ack", 64'(m_ack), 64'(ea));
        chk("m_err", 64'(m_err), 64'(ee));
        chk("timeout_event", 64'(timeout_event), 64'(ref_pulse));
        chk("s_cyc", 64'(s_cyc), 64'(live ? m_cyc[ref_owner] : 1'b0));
        chk("s_stb", 64'(s_stb), 64'(live ? m_stb[ref_owner] : 1'b0));
        chk("s_we", 64'(s_we), 64'(m_we[ref_last]));
        chk("s_adr", 64'(s_adr), 64'(m_adr[ref_last*AW +: AW]));
        chk("s_dat_w", 64'(s_dat_w), 64'(m_dat_w[ref_last*DW +: DW]));
        chk("s_sel", 64'(s_sel), 64'(m_sel[ref_last*SW +: SW]));
        chk("s_cti", 64'(s_cti), 64'(m_cti[ref_last*3 +: 3]));
        chk("m_dat_r", 64'(m_dat_r), 64'(s_dat_r));
    endtask

    task automatic model_next();
        int w;
        if (reset) begin
            model_reset();
        end else if (ref_owner < 0) begin
            ref_pulse = 1'b0;
            w = rr_winner();
            if (w >= 0) begin
                ref_owner = w;
                ref_last  = w;
            end
        end else if (!m_cyc[ref_owner]) begin
            w = rr_winner();
            ref_owner = w;
            if (w >= 0) ref_last = w;
            ref_stall = 0;
            ref_abort = 1'b0;
            ref_pulse = 1'b0;
        end else if (ref_abort) begin
            ref_pulse = 1'b0;
        end else begin
            ref_pulse = 1'b0;
            if (m_stb[ref_owner] && !s_ack && !s_err) begin
                ref_stall++;
                if (ref_stall == TO) begin
                    ref_abort = 1'b1;
                    ref_pulse = 1'b1;
                    ref_stall = 0;
                end
            end else if (s_ack || s_err) begin
                ref_stall = 0;
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked 1ns later, then the model advances.
    task automatic step();
        #1;
        check_outputs();
        model_next();
        @(negedge clk);
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            m_adr[i*AW +: AW]   = AW'($urandom);
            m_dat_w[i*DW +: DW] = $urandom;
            m_sel[i*SW +: SW]   = SW'($urandom);
            m_cti[i*3 +: 3]     = 3'($urandom);
            m_we[i]             = 1'($urandom);
        end
        s_dat_r = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_cti = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        #1;
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_s_cyc", 64'(s_cyc), 64'd0);
        chk("reset_timeout", 64'(timeout_event), 64'd0);
        reset = 1'b0;
        rand_fields();

        // simultaneous request after reset, then direct handover
        m_cyc = 4'b0011; m_stb = 4'b0011;
        step();
        #1 chk("sim_req_grant0", 64'(grant), 64'b0001);
        m_cyc = 4'b0010; m_stb = 4'b0010;
        step();
        #1 chk("handover_grant1", 64'(grant), 64'b0010);
        m_cyc = '0; m_stb = '0;
        step();

        // 8-beat INCR burst by master 1 plus EOB beat while master 0 waits
        m_cyc = 4'b0010; m_stb = 4'b0010;
        step();
        m_cyc = 4'b0011; m_stb = 4'b0011; s_ack = 1'b1;
        for (int b = 0; b < 9; b++) begin
            m_cti[3 +: 3] = (b < 8) ? 3'b010 : 3'b111;
            m_adr[AW +: AW] = AW'(32'h100 + b);
            step();
            #1 chk("burst_grant", 64'(grant), 64'b0010);
        end
        m_cyc = 4'b0001; m_stb = 4'b0001; s_ack = 1'b0;
        step();
        #1 chk("after_burst_grant", 64'(grant), 64'b0001);
        m_cyc = '0; m_stb = '0;
        step();

        // stalled slave: watchdog fires, late ack is dropped
        m_cyc = 4'b0001; m_stb = 4'b0001; s_ack = 1'b0;
        for (int c = 0; c < TO + 1; c++) step();
        #1;
        chk("wd_m_err", 64'(m_err), 64'b0001);
        chk("wd_event", 64'(timeout_event), 64'd1);
        chk("wd_s_cyc", 64'(s_cyc), 64'd0);
        s_ack = 1'b1;
        step();
        #1;
        chk("late_ack_dropped", 64'(m_ack), 64'd0);
        chk("wd_err_one_cycle", 64'(m_err), 64'd0);
        chk("wd_event_one_cycle", 64'(timeout_event), 64'd0);
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        step();

        // ack coincides with owner dropping cyc
        m_cyc = 4'b0011; m_stb = 4'b0011;
        step();
        #1 chk("ack_drop_owner", 64'(grant), 64'b0010);
        m_cyc = 4'b0001; m_stb = 4'b0001; s_ack = 1'b1;
        #1 chk("ack_drop_ack", 64'(m_ack), 64'b0010);
        step();
        #1 chk("ack_drop_next", 64'(grant), 64'b0001);
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        step();

        // reset in the middle of an owned read
        m_cyc = 4'b0001; m_stb = 4'b0001; m_we = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; m_cyc = '0; m_stb = '0;
        #1;
        chk("midreset_s_cyc", 64'(s_cyc), 64'd0);
        chk("midreset_grant", 64'(grant), 64'd0);
        step();
        m_cyc = 4'b0010; m_stb = 4'b0010;
        step();
        #1 chk("post_reset_grant", 64'(grant), 64'b0010);

        // four continuous requesters, one beat each: 0,1,2,3,0
        do_reset();
        m_cyc = 4'b1111; m_stb = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] exp_g;
            exp_g = '0;
            exp_g[k % N] = 1'b1;
            #1 chk("rr4_grant", 64'(grant), 64'(exp_g));
            m_cyc = ~grant; m_stb = ~grant; s_ack = 1'b1;
            step();
        end
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        step();

        // randomized traffic with periodic slave-stall windows
        for (int t = 0; t < 4000; t++) begin
            bit stall_win;
            stall_win = (t % 300) >= 240;
            rand_fields();
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (m_cyc[i]) begin
                    if (stall_win) m_cyc[i] = ($urandom_range(0, 63) != 0);
                    else           m_cyc[i] = ($urandom_range(0, 5) != 0);
                end else begin
                    m_cyc[i] = ($urandom_range(0, 3) == 0);
                end
                m_stb[i] = m_cyc[i] && ($urandom_range(0, 7) != 0);
            end
            if (stall_win) begin
                s_ack = 1'b0;
                s_err = 1'b0;
            end else begin
                s_ack = ($urandom_range(0, 1) == 1);
                s_err = !s_ack && ($urandom_range(0, 15) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone masters (legal range 2..4).
REQ-002 SHALL have parameter ADDR_W, default 30, word address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; SEL width is DATA_W/8.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, stall limit before abort; 0 disables the watchdog.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports m_cyc, m_stb, m_we  input  NUM_MASTERS each  per-master Wishbone control.
REQ-008 SHALL have ports m_adr, m_dat_w, m_sel, m_cti  input  NUM_MASTERS x (ADDR_W, DATA_W, DATA_W/8, 3)  packed per-master request fields, master 0 in the LSBs.
REQ-009 SHALL have ports m_ack, m_err  output  NUM_MASTERS  per-master responses.
REQ-010 SHALL have port m_dat_r  output  DATA_W  read data broadcast to all masters.
REQ-011 SHALL have ports s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, s_cti  output  1/1/1/ADDR_W/DATA_W/DATA_W/8/3  shared slave request.
REQ-012 SHALL have ports s_ack, s_err  input  1, and s_dat_r  input  DATA_W  slave response.
REQ-013 SHALL have port grant  output  NUM_MASTERS  one-hot current owner; all zero when idle.
REQ-014 SHALL have port timeout_event  output  1  single-cycle pulse when the watchdog fires.

Function
REQ-015 SHALL implement the states IDLE, OWNED and ABORT.
REQ-016 IDLE: if any m_cyc is high, SHALL select the first requester searching from (last_owner+1) mod NUM_MASTERS, register grant, and enter OWNED on the next cycle. Arbitration latency is 1 cycle.
REQ-017 OWNED: SHALL mux all s_* request fields from the owner; s_cyc SHALL equal m_cyc[owner].
REQ-018 OWNED: SHALL route s_ack/s_err to the owner only; non-owners SHALL see ack=0 and err=0.
REQ-019 Ownership SHALL persist while m_cyc[owner] is high, including CTI incrementing bursts (3'b010) through end-of-burst (3'b111); there is no preemption.
REQ-020 When m_cyc[owner] falls and another master requests, SHALL hand over directly to the round-robin winner with registered grant (no IDLE cycle); otherwise SHALL go to IDLE with grant=0.
REQ-021 If the owner drops m_cyc in the same cycle as s_ack, the ack SHALL still be delivered to that owner.
REQ-022 last_owner SHALL update on each grant; after reset it SHALL equal NUM_MASTERS-1, so master 0 wins the first simultaneous request.
REQ-023 Watchdog: a counter SHALL increment each OWNED cycle with s_stb=1 and s_ack=s_err=0, and clear on ack, err or state exit; the counter width is clog2(TIMEOUT_CYCLES+1).
REQ-024 When the counter reaches TIMEOUT_CYCLES: enter ABORT, assert m_err[owner] for exactly 1 cycle, pulse timeout_event, and force s_cyc=s_stb=0.
REQ-025 ABORT: s_cyc SHALL stay 0; leave to IDLE/handover (per REQ-020) once m_cyc[owner] is low; a late s_ack SHALL be discarded.
REQ-026 In IDLE, s_cyc and s_stb SHALL be 0, and the other s_* outputs SHALL be don't-care but stable (muxed from last_owner).

Reset
REQ-027 Reset SHALL take effect on the clock edge: state=IDLE, grant=0, last_owner=NUM_MASTERS-1, counter=0, timeout_event=0, m_ack=m_err=0, s_cyc=s_stb=0.
REQ-028 A reset mid-transaction SHALL drop s_cyc the cycle after reset is sampled; the masters are reset alongside.

Structure
REQ-029 The state encoding enum and the CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111) SHALL live in the shared bus package.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs req, last; output one-hot next and valid), purely combinational; this module owns all registers.

Verification
REQ-031 m_cyc=2'b11 raised together after reset -> grant=2'b01 one cycle later; master 0 drops cyc -> grant=2'b10 the next cycle with no IDLE cycle.
REQ-032 Master 1 runs an 8-beat INCR burst while master 0 requests -> grant stays 2'b10 for all 8 acks and the EOB beat; then grant=2'b01.
REQ-033 Slave never acks, TIMEOUT_CYCLES=16 -> after 16 stalled cycles m_err[owner]=1 for 1 cycle, timeout_event=1 for 1 cycle, s_cyc=0; a later s_ack is not forwarded.
REQ-034 s_ack coincides with the owner dropping m_cyc -> m_ack[owner]=1 that cycle, and the other master is granted next cycle.
REQ-035 reset asserted during an OWNED read -> the next cycle s_cyc=0, grant=0, state IDLE; a fresh request from master 1 alone -> grant=2'b10.
REQ-036 NUM_MASTERS=4 with all requesting continuously, each dropping cyc after 1 beat -> grant sequence 0,1,2,3,0; no master is skipped.
